// File: rtl/split_pipe_pkg.sv
// Shared definitions for the split_pipe bus splitter: FSM encoding, error fill
// and the select range check.
package split_pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Replicated across the data width to form the all-ones error response.
    localparam logic ERR_BIT = 1'b1;

    // Non-power-of-2 slave counts leave holes in the select space.
    function automatic logic sel_in_range(input int sel, input int n_slaves);
        return sel < n_slaves;
    endfunction

endpackage

// File: rtl/split_pipe_timeout.sv
// Saturating WAIT-cycle counter for split_pipe; only built when
// SPLIT_PIPE_TIMEOUT_EN is defined.
module split_pipe_timeout #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] PRE_MAX = ~W'(1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != '1)
            cnt <= cnt + 1'b1;
    end

    // Flags the increment that lands on the max value, so the FSM leaves
    // WAIT on exactly the (2^W-1)-th unanswered cycle.
    assign expired = en && (cnt == PRE_MAX);

endmodule

// File: rtl/split_pipe.sv
// Registered transaction-tracking splitter: one master to N_SLAVES slaves,
// select latched per transaction. Optional timeout: SPLIT_PIPE_TIMEOUT_EN.
module split_pipe
    import split_pipe_pkg::*;
#(
    parameter int N_SLAVES  = 2,
    parameter int ADDR_W    = 32,
    parameter int E_ADDR_W  = 0,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8,
    localparam int N_SLAVES_W = $clog2(N_SLAVES),
    localparam int ADDRN_W    = ADDR_W + E_ADDR_W - N_SLAVES_W,
    localparam int STRB_W     = DATA_W / 8,
    localparam int E_PORT_W   = (E_ADDR_W > 0) ? E_ADDR_W : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [E_PORT_W-1:0]                  m_e_addr,
    input  logic                                 m_valid,
    input  logic [ADDR_W-1:0]                    m_addr,
    input  logic [DATA_W-1:0]                    m_wdata,
    input  logic [STRB_W-1:0]                    m_wstrb,
    output logic [DATA_W-1:0]                    m_rdata,
    output logic                                 m_ready,
    output logic [N_SLAVES-1:0]                  s_valid,
    output logic [N_SLAVES-1:0][ADDRN_W-1:0]     s_addr,
    output logic [N_SLAVES-1:0][DATA_W-1:0]      s_wdata,
    output logic [N_SLAVES-1:0][STRB_W-1:0]      s_wstrb,
    input  logic [N_SLAVES-1:0][DATA_W-1:0]      s_rdata,
    input  logic [N_SLAVES-1:0]                  s_ready
);

    typedef struct packed {
        logic [ADDRN_W-1:0] addr;
        logic [DATA_W-1:0]  wdata;
        logic [STRB_W-1:0]  wstrb;
    } req_t;

    logic [ADDR_W+E_ADDR_W-1:0] full_addr;
    logic [N_SLAVES_W-1:0]      sel_in, sel_q;
    logic                       in_range;
    req_t                       req_q;
    state_t                     state, state_nxt;
    logic                       tmo_expired;

    generate
        if (E_ADDR_W > 0) begin : g_eaddr
            assign full_addr = {m_e_addr, m_addr};
        end else begin : g_no_eaddr
            logic unused_e_addr;
            assign full_addr     = m_addr;
            assign unused_e_addr = ^m_e_addr;
        end
    endgenerate

    assign sel_in   = full_addr[ADDR_W+E_ADDR_W-1 -: N_SLAVES_W];
    assign in_range = sel_in_range(int'(sel_in), N_SLAVES);

    wire accept = (state == ST_IDLE) && m_valid;
    wire hit    = (state == ST_WAIT) && s_ready[sel_q];

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (m_valid) state_nxt = in_range ? ST_WAIT : ST_RESP;
            ST_WAIT: if (s_ready[sel_q] || tmo_expired) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= '0;
            req_q   <= '0;
            m_rdata <= '0;
        end else begin
            if (accept) begin
                sel_q <= sel_in;
                req_q <= '{addr: full_addr[ADDRN_W-1:0], wdata: m_wdata, wstrb: m_wstrb};
                if (!in_range)
                    m_rdata <= {DATA_W{ERR_BIT}};
            end
            // A same-cycle slave response beats the timeout.
            if (hit)
                m_rdata <= s_rdata[sel_q];
            else if (state == ST_WAIT && tmo_expired)
                m_rdata <= {DATA_W{ERR_BIT}};
        end
    end

`ifdef SPLIT_PIPE_TIMEOUT_EN
    split_pipe_timeout #(.W(TIMEOUT_W)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept && in_range),
        .en      ((state == ST_WAIT) && !s_ready[sel_q]),
        .expired (tmo_expired)
    );
`else
    localparam int unused_timeout_w = TIMEOUT_W;
    assign tmo_expired = 1'b0;
`endif

    assign m_ready = (state == ST_RESP);

    always_comb begin
        s_valid = '0;
        if (state == ST_WAIT)
            s_valid[sel_q] = 1'b1;
    end

    generate
        for (genvar i = 0; i < N_SLAVES; i++) begin : g_slice
            assign s_addr[i]  = req_q.addr;
            assign s_wdata[i] = req_q.wdata;
            assign s_wstrb[i] = req_q.wstrb;
        end
    endgenerate

endmodule
